// File: rtl/wb_pkg.sv
// Shared definitions for the stream-to-Wishbone write master.
//
// Contents:
//   wr_state_e : FSM state encoding (IDLE, FILL, WRITE, DONE)
//   sel_ones() : all-ones byte-select mask of a given width
package wb_pkg;

    // Two bits cover the four states of the write master.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_e;

    // Widest select the helper can produce (a 512-bit bus would need 64 lanes).
    localparam int MAX_SELECT_WIDTH = 64;

    // Builds a mask with the low 'width' bits set. The caller casts the
    // result down to its own select width.
    function automatic logic [MAX_SELECT_WIDTH-1:0] sel_ones(input int width);
        logic [MAX_SELECT_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_SELECT_WIDTH; i++) begin
            if (i < width) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_stream_hold.sv
// One-entry stream holding register with flow-through.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear_i    : discard any stored word
//   load_i     : a stream handshake is happening this cycle
//   data_i     : stream data
//   last_i     : stream last flag
//   consume_i  : the owner takes the word presented on data_o/last_o
//   full_o     : a word is stored in the register
//   valid_o    : a word is available (stored, or arriving this cycle)
//   data_o     : stored word, or incoming word when empty
//   last_o     : last flag belonging to data_o
module wb_stream_hold #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic                  consume_i,
    output logic                  full_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;

    // When empty, an incoming word is presented straight through so the
    // owner can use it in the same cycle it is handed over; in that case
    // a simultaneous consume leaves the register empty.
    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i && (valid_q || !consume_i)) begin
            data_d  = data_i;
            last_d  = last_i;
            valid_d = 1'b1;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign full_o  = valid_q;
    assign valid_o = valid_q | load_i;
    assign data_o  = valid_q ? data_q : data_i;
    assign last_o  = valid_q ? last_q : last_i;

endmodule

// File: rtl/wb_stream_wr.sv
// Stream-to-Wishbone write master. Words taken from a valid/ready stream
// are written with single Wishbone writes to consecutive word addresses
// starting at a programmed base; completion is reported with a word count.
//
// Optional feature: define WB_STREAM_WR_TIMEOUT_EN to abort a write whose
// ack does not arrive within TIMEOUT_CYCLES strobe cycles (sets err).
//
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   start                   : one-cycle start pulse (honoured in IDLE only)
//   base_adr, max_words     : first byte address and word limit, sampled on start
//   busy, done              : transfer in progress / one-cycle completion pulse
//   trunc, err              : ended on word limit without tlast / aborted by timeout
//   word_count              : words acked in the current or last transfer
//   s_tdata/tvalid/tready/tlast : input stream
//   m_wb_*                  : Wishbone master write port
module wb_stream_wr
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_adr,
    input  logic [COUNT_WIDTH-1:0]  max_words,
    output logic                    busy,
    output logic                    done,
    output logic                    trunc,
    output logic                    err,
    output logic [COUNT_WIDTH-1:0]  word_count,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    output logic [ADDR_WIDTH-1:0]   m_wb_adr_o,
    output logic [DATA_WIDTH-1:0]   m_wb_dat_o,
    output logic                    m_wb_we_o,
    output logic [SELECT_WIDTH-1:0] m_wb_sel_o,
    output logic                    m_wb_stb_o,
    output logic                    m_wb_cyc_o,
    input  logic                    m_wb_ack_i
);

    wr_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [COUNT_WIDTH-1:0]  max_q, max_d;
    logic [COUNT_WIDTH-1:0]  wc_q, wc_d;
    logic [COUNT_WIDTH-1:0]  wcInc;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    last_q, last_d;
    logic                    trunc_q, trunc_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    cyc_q, cyc_d;
    logic                    we_q, we_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;

    logic                    holdLoad;
    logic                    holdConsume;
    logic                    holdClear;
    logic                    holdFull;
    logic                    holdValid;
    logic [DATA_WIDTH-1:0]   holdData;
    logic                    holdLast;
    logic                    timeoutHit;

    assign wcInc = wc_q + COUNT_WIDTH'(1);

    // Byte address of word number 'count'; wraps silently at 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] word_adr(input logic [COUNT_WIDTH-1:0] count);
        return base_q + ADDR_WIDTH'(count) * ADDR_WIDTH'(SELECT_WIDTH);
    endfunction

    // The stream is only accepted while a transfer still needs words: never
    // once the word on the bus is the final one (tlast or word limit), so a
    // terminated transfer leaves nothing behind in the holding register.
    always_comb begin
        s_tready = 1'b0;
        if (state_q == ST_FILL) begin
            s_tready = !holdFull;
        end else if (state_q == ST_WRITE) begin
            s_tready = !holdFull && !last_q && (wcInc != max_q);
        end
    end

    assign holdLoad = s_tvalid && s_tready;

    wb_stream_hold #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (holdClear),
        .load_i   (holdLoad),
        .data_i   (s_tdata),
        .last_i   (s_tlast),
        .consume_i(holdConsume),
        .full_o   (holdFull),
        .valid_o  (holdValid),
        .data_o   (holdData),
        .last_o   (holdLast)
    );

    // Next-state logic. Registered outputs are derived from the next state
    // so that every bus output changes exactly on the transition edge.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        max_d       = max_q;
        wc_d        = wc_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        last_d      = last_q;
        trunc_d     = trunc_q;
        holdConsume = 1'b0;
        holdClear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d    = base_adr;
                    max_d     = max_words;
                    wc_d      = '0;
                    trunc_d   = 1'b0;
                    holdClear = 1'b1;
                    state_d   = (max_words == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (holdValid) begin
                    holdConsume = 1'b1;
                    dat_d       = holdData;
                    last_d      = holdLast;
                    adr_d       = word_adr(wc_q);
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (m_wb_ack_i) begin
                    wc_d = wcInc;
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else if (wcInc == max_q) begin
                        trunc_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (holdValid) begin
                        // Back-to-back: strobe stays up with the next word.
                        holdConsume = 1'b1;
                        dat_d       = holdData;
                        last_d      = holdLast;
                        adr_d       = word_adr(wcInc);
                    end else begin
                        state_d = ST_FILL;
                    end
                end else if (timeoutHit) begin
                    holdClear = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        cyc_d  = (state_d == ST_WRITE);
        we_d   = cyc_d;
        sel_d  = cyc_d ? SELECT_WIDTH'(sel_ones(SELECT_WIDTH)) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            max_q   <= '0;
            wc_q    <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            last_q  <= 1'b0;
            trunc_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            max_q   <= max_d;
            wc_q    <= wc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            last_q  <= last_d;
            trunc_q <= trunc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
        end
    end

`ifdef WB_STREAM_WR_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] toCnt_q, toCnt_d;
    logic          err_q, err_d;

    // The counter holds the number of strobe cycles already spent without
    // ack; the abort fires in the TIMEOUT_CYCLES-th such cycle.
    assign timeoutHit = cyc_q && !m_wb_ack_i && (toCnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        toCnt_d = '0;
        if (cyc_q && !m_wb_ack_i) begin
            toCnt_d = toCnt_q + TW'(1);
        end
        err_d = err_q;
        if (state_q == ST_IDLE && start) begin
            err_d = 1'b0;
        end else if (state_q == ST_WRITE && timeoutHit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toCnt_q <= '0;
            err_q   <= 1'b0;
        end else begin
            toCnt_q <= toCnt_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeoutHit = 1'b0;
    assign err        = 1'b0;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign trunc      = trunc_q;
    assign word_count = wc_q;
    assign m_wb_adr_o = adr_q;
    assign m_wb_dat_o = dat_q;
    assign m_wb_we_o  = we_q;
    assign m_wb_sel_o = sel_q;
    assign m_wb_stb_o = cyc_q;
    assign m_wb_cyc_o = cyc_q;

endmodule

// File: tb/tb_wb_stream_wr.sv
// Directed testbench for wb_stream_wr with a one-cycle-ack Wishbone slave
// model and a table-driven stream source. Expected values are hand-derived.
module tb_wb_stream_wr;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base_adr;
    logic [15:0] max_words;
    logic        busy;
    logic        done;
    logic        trunc;
    logic        err;
    logic [15:0] word_count;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [15:0] m_wb_adr_o;
    logic [31:0] m_wb_dat_o;
    logic        m_wb_we_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_stb_o;
    logic        m_wb_cyc_o;
    logic        m_wb_ack_i;

    int checkCount = 0;
    int errorCount = 0;

    // Stream source: a table of words consumed in order on each handshake.
    logic [31:0] srcData [0:31];
    logic        srcLast [0:31];
    int          srcIdx  = 0;
    int          srcLen  = 0;
    logic        srcFlush = 1'b0;

    // Slave model and write log.
    logic        ackEnable = 1'b1;
    logic        ackR;
    logic [15:0] wrAdr [$];
    logic [31:0] wrDat [$];

    wb_stream_wr #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (16),
        .SELECT_WIDTH  (4),
        .COUNT_WIDTH   (16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_adr   (base_adr),
        .max_words  (max_words),
        .busy       (busy),
        .done       (done),
        .trunc      (trunc),
        .err        (err),
        .word_count (word_count),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .m_wb_adr_o (m_wb_adr_o),
        .m_wb_dat_o (m_wb_dat_o),
        .m_wb_we_o  (m_wb_we_o),
        .m_wb_sel_o (m_wb_sel_o),
        .m_wb_stb_o (m_wb_stb_o),
        .m_wb_cyc_o (m_wb_cyc_o),
        .m_wb_ack_i (m_wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign s_tvalid = (srcIdx < srcLen);
    assign s_tdata  = srcData[srcIdx[4:0]];
    assign s_tlast  = srcLast[srcIdx[4:0]];

    // Advance the source on every accepted word; a flush skips what is left.
    always @(posedge clk) begin
        if (srcFlush) srcIdx <= srcLen;
        else if (s_tvalid && s_tready) srcIdx <= srcIdx + 1;
    end

    // Slave acks the cycle after it samples a strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) ackR <= 1'b0;
        else     ackR <= m_wb_cyc_o && m_wb_stb_o && !ackR && ackEnable;
    end
    assign m_wb_ack_i = ackR;

    always @(posedge clk) begin
        if (m_wb_cyc_o && m_wb_stb_o && m_wb_ack_i) begin
            wrAdr.push_back(m_wb_adr_o);
            wrDat.push_back(m_wb_dat_o);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushWord(input logic [31:0] d, input logic l);
        srcData[srcLen[4:0]] = d;
        srcLast[srcLen[4:0]] = l;
        srcLen++;
    endtask

    task automatic flushSource();
        @(negedge clk);
        srcFlush = 1'b1;
        @(negedge clk);
        srcFlush = 1'b0;
        wrAdr.delete();
        wrDat.delete();
    endtask

    // Pulses start for one cycle; returns at the negedge after start was sampled.
    task automatic applyStimulus(input logic [15:0] base, input logic [15:0] maxW);
        @(negedge clk);
        base_adr  = base;
        max_words = maxW;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, done, 1'b1);
    endtask

    task automatic waitStb(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (!m_wb_stb_o && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, m_wb_stb_o, 1'b1);
    endtask

    initial begin
        int cyc;
        int idx0;
        int lowCnt;
        int ackCnt;

        rst       = 1'b1;
        start     = 1'b0;
        base_adr  = '0;
        max_words = '0;
        repeat (3) @(negedge clk);

        // Reset values.
        checkOutput("rstBusy",  busy, 0);
        checkOutput("rstDone",  done, 0);
        checkOutput("rstTrunc", trunc, 0);
        checkOutput("rstErr",   err, 0);
        checkOutput("rstStb",   m_wb_stb_o, 0);
        checkOutput("rstCyc",   m_wb_cyc_o, 0);
        checkOutput("rstWe",    m_wb_we_o, 0);
        checkOutput("rstAdr",   m_wb_adr_o, 0);
        checkOutput("rstDat",   m_wb_dat_o, 0);
        checkOutput("rstSel",   m_wb_sel_o, 0);
        checkOutput("rstCount", word_count, 0);
        checkOutput("rstReady", s_tready, 0);
        rst = 1'b0;
        @(negedge clk);

        // Frame of three words ending on tlast, below the word limit.
        $display("[TB] tlast-terminated frame");
        pushWord(32'h1111_1111, 1'b0);
        pushWord(32'h2222_2222, 1'b0);
        pushWord(32'h3333_3333, 1'b1);
        applyStimulus(16'h0100, 16'd4);
        checkOutput("t1Busy", busy, 1);
        waitStb("t1Stb", 10, cyc);
        checkOutput("t1Sel", m_wb_sel_o, 4'hF);
        checkOutput("t1We",  m_wb_we_o, 1);
        checkOutput("t1Adr0", m_wb_adr_o, 16'h0100);
        waitDone("t1Done", 50, cyc);
        checkOutput("t1Writes", wrAdr.size(), 3);
        if (wrAdr.size() == 3) begin
            checkOutput("t1AdrA", wrAdr[0], 16'h0100);
            checkOutput("t1AdrB", wrAdr[1], 16'h0104);
            checkOutput("t1AdrC", wrAdr[2], 16'h0108);
            checkOutput("t1DatC", wrDat[2], 32'h3333_3333);
        end
        checkOutput("t1Count", word_count, 3);
        checkOutput("t1Trunc", trunc, 0);
        checkOutput("t1Err",   err, 0);
        checkOutput("t1CycAtDone", m_wb_cyc_o, 0);
        @(negedge clk);
        checkOutput("t1DonePulse", done, 0);
        checkOutput("t1BusyIdle",  busy, 0);
        flushSource();

        // Word limit reached before tlast; surplus words must stall.
        $display("[TB] truncated frame");
        idx0 = srcIdx;
        for (int i = 0; i < 5; i++) pushWord(32'hA000_0000 + 32'(i), 1'b0);
        applyStimulus(16'h0040, 16'd2);
        waitDone("t2Done", 50, cyc);
        checkOutput("t2Writes", wrAdr.size(), 2);
        if (wrAdr.size() == 2) begin
            checkOutput("t2AdrB", wrAdr[1], 16'h0044);
            checkOutput("t2DatB", wrDat[1], 32'hA000_0001);
        end
        checkOutput("t2Trunc", trunc, 1);
        checkOutput("t2Count", word_count, 2);
        repeat (4) @(negedge clk);
        checkOutput("t2ReadyLow", s_tready, 0);
        checkOutput("t2Accepted", srcIdx - idx0, 2);
        flushSource();

        // Address wrap at the top of the address space.
        $display("[TB] address wrap");
        for (int i = 0; i < 3; i++) pushWord(32'hB000_0000 + 32'(i), 1'b0);
        applyStimulus(16'hFFFC, 16'd3);
        waitDone("t3Done", 50, cyc);
        checkOutput("t3Writes", wrAdr.size(), 3);
        if (wrAdr.size() == 3) begin
            checkOutput("t3AdrA", wrAdr[0], 16'hFFFC);
            checkOutput("t3AdrB", wrAdr[1], 16'h0000);
            checkOutput("t3AdrC", wrAdr[2], 16'h0004);
        end
        checkOutput("t3Trunc", trunc, 1);
        flushSource();

        // Sustained throughput: stb held, one ack every two cycles.
        $display("[TB] sustained stream");
        for (int i = 0; i < 6; i++) pushWord(32'hC000_0000 + 32'(i), 1'b0);
        applyStimulus(16'h0200, 16'd4);
        @(negedge clk);
        checkOutput("t4StartToStb", m_wb_stb_o, 1);
        lowCnt = 0;
        ackCnt = 0;
        cyc    = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!done && !m_wb_stb_o) lowCnt++;
            if (m_wb_ack_i) ackCnt++;
        end
        checkOutput("t4Done", done, 1);
        checkOutput("t4StbToDone", cyc, 8);
        checkOutput("t4StbGaps", lowCnt, 0);
        checkOutput("t4Acks", ackCnt, 4);
        checkOutput("t4Count", word_count, 4);
        flushSource();

        // Zero word limit: done right away, no bus cycle.
        $display("[TB] zero word limit");
        applyStimulus(16'h0300, 16'd0);
        checkOutput("t5Done", done, 1);
        checkOutput("t5Cyc",  m_wb_cyc_o, 0);
        checkOutput("t5Busy", busy, 1);
        checkOutput("t5Count", word_count, 0);
        @(negedge clk);
        checkOutput("t5DonePulse", done, 0);

        // Reset in the middle of a write, then restart from a new base.
        $display("[TB] reset during write");
        for (int i = 0; i < 4; i++) pushWord(32'hD000_0000 + 32'(i), 1'b0);
        applyStimulus(16'h0400, 16'd4);
        waitStb("t6Stb", 10, cyc);
        rst = 1'b1;
        #1;
        checkOutput("t6RstStb", m_wb_stb_o, 0);
        checkOutput("t6RstCyc", m_wb_cyc_o, 0);
        checkOutput("t6RstBusy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        flushSource();
        pushWord(32'hCAFE_F00D, 1'b1);
        applyStimulus(16'h0500, 16'd1);
        waitDone("t6Done", 50, cyc);
        checkOutput("t6Writes", wrAdr.size(), 1);
        if (wrAdr.size() == 1) begin
            checkOutput("t6Adr", wrAdr[0], 16'h0500);
            checkOutput("t6Dat", wrDat[0], 32'hCAFE_F00D);
        end
        checkOutput("t6Trunc", trunc, 0);
        flushSource();

`ifdef WB_STREAM_WR_TIMEOUT_EN
        // Slave never acks: the write is abandoned after 8 strobe cycles.
        $display("[TB] ack timeout");
        ackEnable = 1'b0;
        pushWord(32'hEEEE_0000, 1'b0);
        applyStimulus(16'h0600, 16'd3);
        waitStb("t7Stb", 10, cyc);
        cyc = 0;
        while (m_wb_stb_o && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        checkOutput("t7StbCycles", cyc, 8);
        checkOutput("t7Done", done, 1);
        checkOutput("t7Err", err, 1);
        checkOutput("t7Count", word_count, 0);
        ackEnable = 1'b1;
        flushSource();
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
